// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - data-stack sequencer between Forth decode and the stack RAM block
//
// Purpose:
//   Accepts one stack primitive at a time on a valid/ready handshake. It
//   expands each primitive into one or two write cycles on the stack block's
//   TWrite/NWrite/WData/Offset controls. It tracks stack depth and squashes
//   any operation that would underflow or overflow, or that has an illegal
//   opcode. Each such event sets a sticky error flag.
//
// Ports:
//   Clk, Rst           clock; synchronous active-high reset (shared with stack block)
//   OpValid/OpReady    operation handshake from decode
//   Op[3:0]            0 NOP 1 PUSH 2 DROP 3 DUP 4 SWAP 5 OVER 6 ADD 7 SUB, 8-15 illegal
//   OpData[15:0]       PUSH literal
//   Done               one-cycle pulse in the final cycle of every accepted op
//   Depth[7:0]         current number of stack entries
//   ErrUnder/ErrOver/ErrIllegal  sticky error flags, cleared by ErrClr
//   TWrite, NWrite     stack write strobes (top+Offset, top+Offset-1)
//   WData[15:0]        stack write data
//   Offset[7:0]        signed stack pointer delta, applied by the stack every edge
//   T, N [15:0]        combinational top/next from the stack block

module stack_ctrl (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        OpValid,
    input  logic [3:0]  Op,
    input  logic [15:0] OpData,
    output logic        OpReady,
    output logic        Done,
    output logic [7:0]  Depth,
    output logic        ErrUnder,
    output logic        ErrOver,
    output logic        ErrIllegal,
    input  logic        ErrClr,
    output logic        TWrite,
    output logic        NWrite,
    output logic [15:0] WData,
    output logic [7:0]  Offset,
    input  logic [15:0] T,
    input  logic [15:0] N
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_DROP = 4'd2;
    localparam logic [3:0] OP_DUP  = 4'd3;
    localparam logic [3:0] OP_SWAP = 4'd4;
    localparam logic [3:0] OP_OVER = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;

    localparam logic [7:0] OFS_ZERO = 8'h00;
    localparam logic [7:0] OFS_INC  = 8'h01;
    localparam logic [7:0] OFS_DEC  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SWAP2 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] data_q, data_d;
    logic [15:0] save_q, save_d;
    logic [7:0]  depth_q, depth_d;
    logic        err_under_q, err_under_d;
    logic        err_over_q, err_over_d;
    logic        err_ill_q, err_ill_d;

    logic        op_ready;
    logic        done;
    logic        t_write;
    logic        n_write;
    logic [15:0] w_data;
    logic [7:0]  offset;

    // Guard decode for the registered op
    logic [1:0]  req_depth;
    logic        grows;
    logic        shrinks;
    logic        is_illegal;
    logic        is_under;
    logic        is_over;
    logic        guard_fail;

    always_comb begin
        req_depth = 2'd0;
        grows     = 1'b0;
        shrinks   = 1'b0;
        case (op_q)
            OP_PUSH: grows = 1'b1;
            OP_DROP: begin req_depth = 2'd1; shrinks = 1'b1; end
            OP_DUP:  begin req_depth = 2'd1; grows   = 1'b1; end
            OP_SWAP: req_depth = 2'd2;
            OP_OVER: begin req_depth = 2'd2; grows   = 1'b1; end
            OP_ADD:  begin req_depth = 2'd2; shrinks = 1'b1; end
            OP_SUB:  begin req_depth = 2'd2; shrinks = 1'b1; end
            default: ;
        endcase
        is_illegal = op_q[3];
        is_under   = depth_q < {6'd0, req_depth};
        // Only +1 ops can overflow; depth is capped at 255.
        is_over    = grows && (depth_q == 8'hFF);
        guard_fail = is_illegal || is_under || is_over;
    end

    // Next-state and stack control outputs
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        save_d   = save_q;
        depth_d  = depth_q;
        op_ready = 1'b0;
        done     = 1'b0;
        t_write  = 1'b0;
        n_write  = 1'b0;
        w_data   = 16'h0000;
        offset   = OFS_ZERO;

        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (OpValid) begin
                    op_d    = Op;
                    data_d  = OpData;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                done    = 1'b1;
                state_d = S_IDLE;
                // A squashed op leaves all stack controls at their idle values.
                if (!guard_fail) begin
                    case (op_q)
                        OP_PUSH: begin
                            t_write = 1'b1;
                            w_data  = data_q;
                            offset  = OFS_INC;
                        end
                        OP_DROP: begin
                            offset  = OFS_DEC;
                        end
                        OP_DUP: begin
                            t_write = 1'b1;
                            w_data  = T;
                            offset  = OFS_INC;
                        end
                        OP_OVER: begin
                            t_write = 1'b1;
                            w_data  = N;
                            offset  = OFS_INC;
                        end
                        OP_ADD: begin
                            t_write = 1'b1;
                            w_data  = N + T;
                            offset  = OFS_DEC;
                        end
                        OP_SUB: begin
                            t_write = 1'b1;
                            w_data  = N - T;
                            offset  = OFS_DEC;
                        end
                        OP_SWAP: begin
                            // Old T is kept so the second cycle can write it into N.
                            t_write = 1'b1;
                            w_data  = N;
                            save_d  = T;
                            done    = 1'b0;
                            state_d = S_SWAP2;
                        end
                        default: ;
                    endcase
                    if (grows) begin
                        depth_d = depth_q + 8'd1;
                    end else if (shrinks) begin
                        depth_d = depth_q - 8'd1;
                    end
                end
            end

            S_SWAP2: begin
                n_write = 1'b1;
                w_data  = save_q;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Sticky error flags: a new error in the same cycle as ErrClr wins.
    always_comb begin
        err_under_d = (err_under_q & ~ErrClr) | ((state_q == S_EXEC) & is_under);
        err_over_d  = (err_over_q  & ~ErrClr) | ((state_q == S_EXEC) & is_over);
        err_ill_d   = (err_ill_q   & ~ErrClr) | ((state_q == S_EXEC) & is_illegal);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            data_q      <= 16'h0000;
            save_q      <= 16'h0000;
            depth_q     <= 8'd0;
            err_under_q <= 1'b0;
            err_over_q  <= 1'b0;
            err_ill_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            save_q      <= save_d;
            depth_q     <= depth_d;
            err_under_q <= err_under_d;
            err_over_q  <= err_over_d;
            err_ill_q   <= err_ill_d;
        end
    end

    assign OpReady    = op_ready;
    assign Done       = done;
    assign Depth      = depth_q;
    assign ErrUnder   = err_under_q;
    assign ErrOver    = err_over_q;
    assign ErrIllegal = err_ill_q;
    assign TWrite     = t_write;
    assign NWrite     = n_write;
    assign WData      = w_data;
    assign Offset     = offset;

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencer that sits between the Forth decode stage and the data-stack RAM block, and drives that block's TWrite/NWrite/WData/Offset controls. It accepts one stack primitive at a time over a valid/ready handshake and expands it into one or two stack write cycles. It tracks stack depth and blocks any operation that would underflow or overflow, reporting it through sticky error flags.

## Interface
- No parameters. Widths are fixed: data 16, depth 8, Offset signed 8.
- Clk  in  1  system clock; all state changes on its rising edge.
- Rst  in  1  synchronous, active-high reset; shared with the stack block.
- OpValid  in  1  decode presents an operation.
- Op  in  4  opcode: 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 ADD, 7 SUB; 8-15 illegal.
- OpData  in  16  literal for PUSH; ignored otherwise.
- OpReady  out  1  controller can accept an op.
- Done  out  1  one-cycle pulse in the final cycle of an op.
- Depth  out  8  current number of stack entries (0..255).
- ErrUnder  out  1  sticky underflow flag.
- ErrOver  out  1  sticky overflow flag.
- ErrIllegal  out  1  sticky illegal-opcode flag.
- ErrClr  in  1  clears all three Err flags.
- TWrite, NWrite  out  1 each  stack write strobes.
- WData  out  16  stack write data.
- Offset  out  8 signed  stack pointer delta, applied on every clock edge.
- T, N  in  16 each  stack top and next, read combinationally from the stack block.

## Operation
- States: IDLE, EXEC, SWAP2.
  - OpReady=1 only in IDLE.
  - An op is accepted on an edge where OpValid&&OpReady. Op and OpData are registered, and IDLE→EXEC.
- In IDLE and any non-write cycle: Offset=0, TWrite=NWrite=0, WData=0. The stack moves its pointer every clock, so this is mandatory.
- EXEC behaviour by op. Required depth and depth delta are in brackets. Writes land at top+Offset (TWrite) and top+Offset-1 (NWrite).
  - NOP [0, 0]: no write.
  - PUSH [0, +1]: TWrite, WData=OpData, Offset=+1.
  - DROP [1, -1]: Offset=-1, no write.
  - DUP [1, +1]: TWrite, WData=T, Offset=+1.
  - OVER [2, +1]: TWrite, WData=N, Offset=+1.
  - ADD [2, -1]: TWrite, WData=N+T mod 2^16, Offset=-1.
  - SUB [2, -1]: TWrite, WData=N-T mod 2^16, Offset=-1.
  - SWAP [2, 0], first cycle: TWrite, WData=N, Offset=0. Latch T into a save register, then EXEC→SWAP2.
- SWAP2: NWrite, WData=saved T, Offset=0.
- Done is asserted in the final cycle: EXEC for all ops except SWAP, SWAP2 for SWAP. The next state is IDLE.
- Depth is updated by the delta on the same edge the stack applies Offset.
- Guard checks are evaluated in EXEC before any write.
  - If Depth < required depth: set ErrUnder.
  - If Depth + delta > 255: set ErrOver.
  - If Op ≥ 8: set ErrIllegal.
  - On any guard failure the op is squashed: Offset=0, no writes, Depth unchanged. Done still pulses and the state returns to IDLE. SWAP squashed in EXEC does not enter SWAP2.
- Err flags are sticky. ErrClr clears them on the next edge. If a new error and ErrClr occur in the same cycle, the new error wins and the flag stays 1.
- Errors do not block later ops.

## Timing
- Reset values: state IDLE, OpReady=1, Done=0, Depth=0, all Err=0, TWrite=NWrite=0, WData=0, Offset=0, save register 0.
- Rst takes priority over everything. Rst mid-SWAP (in SWAP2) abandons the second write, and the stack is cleared by the same Rst.
- Latency and throughput:
  - Accept at edge k. EXEC spans k→k+1 and the stack updates at k+1.
  - Single-cycle ops: OpReady is high again after k+1, so the next op can be accepted at edge k+2. Throughput is one op per 2 cycles.
  - SWAP: SWAP2 spans k+1→k+2 and OpReady is high after k+2. Throughput is one op per 3 cycles.
- T and N are sampled combinationally during EXEC. They reflect all previously completed ops.
- OpValid while OpReady=0 is ignored. Decode holds Op and OpData until accepted.

## Test plan
- After Rst: PUSH 0x1234, then PUSH 0xABCD. Required: Depth=2, T=0xABCD, N=0x1234. Each op shows one Done pulse and a 2-cycle spacing between accepts.
- From stack [0x0005, 0x0003] (T=3): SUB. Required: T=0x0002, Depth=1. Then DUP, ADD. Required: T=0x0004, Depth=1.
- From stack T=0x00AA, N=0x0055: SWAP. Required: Done in the 2nd exec cycle, T=0x0055, N=0x00AA, Depth unchanged, OpReady low for 2 cycles.
- Underflow and illegal opcode:
  - From Depth=1: OVER. Required: ErrUnder=1, no TWrite, Depth=1, T unchanged.
  - ErrClr. Required: flag=0.
  - Op=0xF. Required: ErrIllegal=1.
- Overflow: 255 PUSHes reach Depth=255. The 256th PUSH sets ErrOver, leaves Depth=255, and leaves T equal to the 255th value.
- Reset mid-op: accept SWAP, assert Rst during SWAP2. Required next cycle: Depth=0, OpReady=1, Offset=0, T=0, N=0.
